// File: rtl/multiply_add.sv
// Sequential shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// One multiplier bit per clock, LSB first, with a level start/done handshake.
module multiply_add #(
    parameter int BIT_DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BIT_DEPTH-1:0]   multiplicand,
    input  logic [BIT_DEPTH-1:0]   multiplier,
    input  logic [BIT_DEPTH-1:0]   addend,
    output logic [2*BIT_DEPTH-1:0] product,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [BIT_DEPTH-1:0]   mcand;
    logic [BIT_DEPTH-1:0]   mplier;
    logic [CW-1:0]          count;
    logic [2*BIT_DEPTH-1:0] acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (count == LAST) state_nxt = DONE;
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator is 2*BIT_DEPTH wide; A*B+C can never exceed it, so no carry-out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            acc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= multiplicand;
                        mplier <= multiplier;
                        acc    <= {{BIT_DEPTH{1'b0}}, addend};
                        count  <= '0;
                    end
                end
                BUSY: begin
                    if (mplier[count])
                        acc <= acc + ({{BIT_DEPTH{1'b0}}, mcand} << count);
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = acc;
    assign busy    = (state == BUSY);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_multiply_add.sv
// Bench for multiply_add: directed and random operands against an arithmetic
// model, plus latency, handshake and asynchronous-reset checks.
module tb_multiply_add;

    localparam int BD = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BD-1:0] multiplicand, multiplier, addend;
    logic [2*BD-1:0] product;
    logic          busy, done;

    int n_vec = 0;
    int n_err = 0;

    multiply_add #(.BIT_DEPTH(BD)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        return 64'(a) * 64'(b) + 64'(c);
    endfunction

    // Load on one edge, scramble operands throughout BUSY, then expect done
    // exactly BD edges after the load edge. Optionally hold start in DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input int hold);
        logic [63:0] exp;
        int bad;
        exp = model(a, b, c);
        @(negedge clk);
        multiplicand = a; multiplier = b; addend = c; start = 1'b1;
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < BD; k++) begin
            if (!busy || done) bad++;
            @(negedge clk);
            multiplicand = $urandom; multiplier = $urandom; addend = $urandom;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_window"}, 64'(bad), 64'd0);
        chk({tag, "_done"}, {62'd0, busy, done}, 64'd1);
        chk({tag, "_product"}, product, exp);
        if (hold > 0) begin
            bad = 0;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                if (!done || busy || product !== exp) bad++;
            end
            chk({tag, "_hold"}, 64'(bad), 64'd0);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_idle_done"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_idle_product"}, product, exp);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        multiplicand = '0; multiplier = '0; addend = '0;
        #1;
        chk("reset_state", {product[61:0], busy, done}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        run_op("a25_b4",      32'd25,  32'd4,     32'd0,   0);
        run_op("a22_b56_c2",  32'd22,  32'd56,    32'd2,   0);
        chk("const_1234", product, 64'd1234);
        run_op("a257_b255",   32'd257, 32'd255,   32'd0,   0);
        chk("const_65535", product, 64'd65535);
        run_op("all_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("const_max", product, 64'hFFFF_FFFF_0000_0000);
        run_op("zero_a",      32'd0,   32'd12345, 32'd100, 0);

        // Asynchronous reset 10 cycles into a computation.
        @(negedge clk);
        multiplicand = 32'hDEAD_BEEF; multiplier = 32'h1234_5678; addend = 32'd7; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midop_reset", {product[61:0], busy, done}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", {product[61:0], busy, done}, 64'd0);
        run_op("after_reset", 32'd1000, 32'd3000, 32'd5, 0);

        // start held high for 100 cycles in DONE, then a fresh computation.
        run_op("hold", 32'hABCD, 32'h1234, 32'h99, 100);
        run_op("restart", 32'd77, 32'd88, 32'd9, 0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb, rc;
            ra = $urandom; rb = $urandom; rc = $urandom;
            if (i % 5 == 1) rb = 32'hFFFF_FFFF;
            if (i % 5 == 3) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), ra, rb, rc, (i % 4 == 0) ? 3 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multiply_add.md
Name: multiply_add

Overview:
- Sequential shift-add multiply-accumulate unit. It computes product = multiplicand * multiplier + addend.
- It is the inverse companion of the sequential divider: feeding it a quotient, divisor and remainder reconstructs the dividend.
- Used in self-checking datapaths and in arithmetic test fixtures on DE2-115.
- Uses the same start/done level handshake as the divider, so the two blocks are driven identically.

Parameters:
- BIT_DEPTH, 32, width of each operand; product is 2*BIT_DEPTH wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level request; sampled only in IDLE.
- multiplicand  input  BIT_DEPTH  operand A, unsigned.
- multiplier  input  BIT_DEPTH  operand B, unsigned.
- addend  input  BIT_DEPTH  operand C, unsigned, zero-extended.
- product  output  2*BIT_DEPTH  A*B+C, unsigned.
- busy  output  1  high while computing (BUSY state).
- done  output  1  high while the result is valid (DONE state).

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - state=IDLE; product=0; done=0; busy=0; internal operand registers and counter cleared.
  - Reset mid-operation aborts the computation with no partial result kept.
  - After reset deasserts, the first rising edge is a normal IDLE cycle.
- States: IDLE, BUSY, DONE, registered. done and busy are decoded directly from the state (done = DONE, busy = BUSY); no combinational path from inputs to outputs.
- IDLE:
  - If start=1 at a rising edge: latch multiplicand and multiplier; accumulator (product register) <= zero-extended addend; bit counter <= 0; go to BUSY.
  - Else stay in IDLE; product keeps its last value.
- BUSY, one multiplier bit per cycle, LSB first:
  - Per edge: if the latched multiplier bit[count]=1, accumulator += (zero-extended multiplicand << count); count increments.
  - On the edge that processes bit BIT_DEPTH-1, go to DONE.
  - Fixed latency: no early exit on zero operands.
  - start and all operand inputs are ignored in BUSY; changing them has no effect.
- DONE:
  - done=1 and product holds the final value.
  - Stay in DONE while start=1.
  - When start=0 at a rising edge, go to IDLE; done falls and product stays held.
  - A new operation therefore requires start to drop and re-rise (re-sampled in IDLE). start held high continuously never triggers a second computation.
- Latency: start is sampled at edge E0; done is high after edge E0+BIT_DEPTH (BIT_DEPTH BUSY cycles). For BIT_DEPTH=32, done rises 32 clocks after the load edge.
- Width rule: accumulation is 2*BIT_DEPTH wide. (2^N-1)^2 + (2^N-1) = 2^2N - 2^N, so the result never overflows and no carry-out is needed.
- Invariant: product changes only on the IDLE load edge and on BUSY edges.

Test Plan:
- BIT_DEPTH=32:
  - A=25, B=4, C=0 -> product=100; done rises exactly 32 clocks after the load edge; busy high for 32 cycles.
  - A=22, B=56, C=2 -> 1234; then A=257, B=255, C=0 -> 65535. Operands are changed during BUSY to garbage; the result must be unaffected.
  - A=B=C=0xFFFFFFFF -> product=0xFFFFFFFF00000000.
  - A=0, B=12345, C=100 -> product=100 with the full 32-cycle latency (no early exit).
- Reset and handshake:
  - Pull reset low 10 cycles into a computation -> product=0, done=0, busy=0 immediately (before the next edge). A fresh start afterwards gives the correct result.
  - Hold start=1 for 100 cycles after done -> done stays high, product stable, no restart. Dropping start returns to IDLE (done=0 next edge). Re-asserting start begins a new 32-cycle computation.
